// File: rtl/guess_pkg.sv
// ============================================================================
// Module : guess_pkg
// Desc   : Shared FSM states, key codes and code table for the guess judge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package guess_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_JUDGE = 2'd1,
        ST_SHOW  = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLR = 4'd12;
    localparam logic [3:0] KEY_ENT = 4'd14;
    localparam logic [3:0] KEY_NEW = 4'd15;

    // Every entry has four pairwise-distinct BCD digits.
    function automatic logic [15:0] code_table(input logic [3:0] idx);
        logic [15:0] code;
        case (idx)
            4'd0:    code = 16'h1234;
            4'd1:    code = 16'h5678;
            4'd2:    code = 16'h9012;
            4'd3:    code = 16'h3456;
            4'd4:    code = 16'h7890;
            4'd5:    code = 16'h2468;
            4'd6:    code = 16'h1357;
            4'd7:    code = 16'h8024;
            4'd8:    code = 16'h6193;
            4'd9:    code = 16'h4705;
            4'd10:   code = 16'h2951;
            4'd11:   code = 16'h7386;
            4'd12:   code = 16'h5120;
            4'd13:   code = 16'h9437;
            4'd14:   code = 16'h3608;
            default: code = 16'h8271;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/guess_judge_if.sv
// ============================================================================
// Module : guess_judge_if
// Desc   : Keypad input and judged-result bundle for guess_judge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface guess_judge_if;
    logic       key_valid;
    logic [3:0] keypadBuf;
    logic [2:0] r_a;
    logic [2:0] r_b;
    logic       show;
    logic       win;
    logic [2:0] entry_cnt;
    logic [3:0] tries;

    modport master (
        output key_valid, keypadBuf,
        input  r_a, r_b, show, win, entry_cnt, tries
    );

    modport slave (
        input  key_valid, keypadBuf,
        output r_a, r_b, show, win, entry_cnt, tries
    );
endinterface

`default_nettype wire

// File: rtl/guess_code_rom.sv
// ============================================================================
// Module : guess_code_rom
// Desc   : Free-running 4-bit counter indexing the secret-code table.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module guess_code_rom
    import guess_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    output logic [15:0]      o_code
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= 4'd0;
        else     r_cnt <= r_cnt + 4'd1;
    end

    assign o_code = code_table(r_cnt);

endmodule

`default_nettype wire

// File: rtl/guess_judge.sv
// ============================================================================
// Module : guess_judge
// Desc   : Four-digit bulls-and-cows judge; GUESS_RANDOM_EN picks secrets from
//          a table on each new game.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module guess_judge
    import guess_pkg::*;
#(
    parameter logic [15:0] SECRET = 16'h1234
) (
    input  wire logic       clk,
    input  wire logic       rst,
    guess_judge_if.slave    bus
);

    state_t      r_state, w_next;
    logic [15:0] r_guess, r_secret, w_reload;
    logic [2:0]  r_entry_cnt, r_res_a, r_res_b, r_acc_a, r_acc_b, r_idx;
    logic [3:0]  r_tries, w_key, w_gdig;
    logic        w_is_digit, w_new, w_clr, w_ent, w_dup, w_room, w_full;
    logic        w_judge_done, w_hit_a, w_hit_b;

`ifdef GUESS_RANDOM_EN
    guess_code_rom u_code_rom (
        .clk    (clk),
        .rst    (rst),
        .o_code (w_reload)
    );
`else
    assign w_reload = SECRET;
`endif

    assign w_key        = bus.keypadBuf;
    assign w_is_digit   = bus.key_valid && (w_key <= 4'd9);
    assign w_new        = bus.key_valid && (w_key == KEY_NEW);
    assign w_clr        = bus.key_valid && (w_key == KEY_CLR);
    assign w_ent        = bus.key_valid && (w_key == KEY_ENT);
    assign w_full       = (r_entry_cnt == 3'd4);
    assign w_room       = !w_full;
    assign w_judge_done = (r_idx == 3'd4);

    // Only the entered positions (0..entry_cnt-1) take part in the duplicate test.
    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((r_entry_cnt > k[2:0]) && (r_guess[k*4 +: 4] == w_key))
                w_dup = 1'b1;
        end
    end

    assign w_gdig  = r_guess[{r_idx[1:0], 2'b00} +: 4];
    assign w_hit_a = (w_gdig == r_secret[{r_idx[1:0], 2'b00} +: 4]);

    always_comb begin
        w_hit_b = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((j[1:0] != r_idx[1:0]) && (r_secret[j*4 +: 4] == w_gdig))
                w_hit_b = !w_hit_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ENTRY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_new) begin
            w_next = ST_ENTRY;
        end else begin
            case (r_state)
                ST_ENTRY: if (w_ent && w_full) w_next = ST_JUDGE;
                ST_JUDGE: if (w_judge_done)
                              w_next = (r_acc_a == 3'd4) ? ST_WIN : ST_SHOW;
                ST_SHOW:  if (w_is_digit || w_clr) w_next = ST_ENTRY;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guess     <= 16'h0000;
            r_secret    <= SECRET;
            r_entry_cnt <= 3'd0;
            r_res_a     <= 3'd0;
            r_res_b     <= 3'd0;
            r_acc_a     <= 3'd0;
            r_acc_b     <= 3'd0;
            r_idx       <= 3'd0;
            r_tries     <= 4'd0;
        end else if (w_new) begin
            r_guess     <= 16'h0000;
            r_secret    <= w_reload;
            r_entry_cnt <= 3'd0;
            r_res_a     <= 3'd0;
            r_res_b     <= 3'd0;
            r_acc_a     <= 3'd0;
            r_acc_b     <= 3'd0;
            r_idx       <= 3'd0;
            r_tries     <= 4'd0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_is_digit && w_room && !w_dup) begin
                        r_guess     <= {r_guess[11:0], w_key};
                        r_entry_cnt <= r_entry_cnt + 3'd1;
                    end else if (w_clr) begin
                        r_guess     <= 16'h0000;
                        r_entry_cnt <= 3'd0;
                    end else if (w_ent && w_full) begin
                        r_idx   <= 3'd0;
                        r_acc_a <= 3'd0;
                        r_acc_b <= 3'd0;
                    end
                end
                ST_JUDGE: begin
                    if (!w_judge_done) begin
                        if (w_hit_a) r_acc_a <= r_acc_a + 3'd1;
                        if (w_hit_b) r_acc_b <= r_acc_b + 3'd1;
                        r_idx <= r_idx + 3'd1;
                    end else begin
                        r_res_a     <= r_acc_a;
                        r_res_b     <= r_acc_b;
                        r_entry_cnt <= 3'd0;
                        if (r_tries != 4'd15) r_tries <= r_tries + 4'd1;
                    end
                end
                ST_SHOW: begin
                    if (w_is_digit) begin
                        r_guess     <= {12'h000, w_key};
                        r_entry_cnt <= 3'd1;
                    end else if (w_clr) begin
                        r_guess     <= 16'h0000;
                        r_entry_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.r_a       = r_res_a;
    assign bus.r_b       = r_res_b;
    assign bus.show      = (r_state == ST_SHOW) || (r_state == ST_WIN);
    assign bus.win       = (r_state == ST_WIN);
    assign bus.entry_cnt = r_entry_cnt;
    assign bus.tries     = r_tries;

endmodule

`default_nettype wire
